// File: rtl/mem_ctrl.sv
// Byte-serial memory controller between the load/store buffer, instruction fetch
// and a byte-wide RAM/IO bus; assembles little-endian words and pulses done per request.
module mem_ctrl #(
  parameter int IO_SEL_HI = 17,
  parameter int IO_SEL_LO = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        clear,
  input  logic        lsb_req,
  input  logic        lsb_type,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [2:0]  len_r, len_s;
  logic [31:0] base_r, base_s;
  logic [31:0] wdata_r, wdata_s;
  logic        fetch_r, fetch_s;
  logic [31:0] buf_r, buf_s;
  logic        ready_q_r;
  logic        mem_wr_r, mem_wr_s;
  logic        lsb_done_r, lsb_done_s;
  logic        if_done_r, if_done_s;
  logic [31:0] lsb_rdata_r, lsb_rdata_s;
  logic [31:0] if_data_r, if_data_s;
  logic [31:0] mem_a_r, mem_a_s;
  logic [7:0]  mem_dout_r, mem_dout_s;
  logic [2:0]  step_s;
  logic [31:0] byte_addr_s;
  logic [31:0] asm_s;

  function automatic logic is_io(input logic [31:0] a);
    return a[IO_SEL_HI:IO_SEL_LO] == 2'b11;
  endfunction

  function automatic logic [2:0] byte_count(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Next-state and next-output logic; everything holds while ready is low.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    len_s       = len_r;
    base_s      = base_r;
    wdata_s     = wdata_r;
    fetch_s     = fetch_r;
    buf_s       = buf_r;
    mem_wr_s    = mem_wr_r;
    lsb_done_s  = lsb_done_r;
    if_done_s   = if_done_r;
    lsb_rdata_s = lsb_rdata_r;
    if_data_s   = if_data_r;
    mem_a_s     = mem_a_r;
    mem_dout_s  = mem_dout_r;
    step_s      = cnt_r;
    byte_addr_s = base_r;
    asm_s       = buf_r;
    if (ready) begin
      lsb_done_s = 1'b0;
      if_done_s  = 1'b0;
      case (state_r)
        IDLE: begin
          if (lsb_req) begin
            base_s  = lsb_addr;
            len_s   = byte_count(lsb_len);
            fetch_s = 1'b0;
            cnt_s   = 3'd0;
            buf_s   = 32'h0000_0000;
            mem_a_s = lsb_addr;
            if (lsb_type) begin
              state_s    = WRITE;
              wdata_s    = lsb_wdata;
              mem_dout_s = lsb_wdata[7:0];
              mem_wr_s   = !(is_io(lsb_addr) && io_buffer_full);
            end else begin
              state_s  = READ;
              mem_wr_s = 1'b0;
            end
          end else if (if_req && !clear) begin
            state_s  = READ;
            base_s   = if_addr;
            len_s    = 3'd4;
            fetch_s  = 1'b1;
            cnt_s    = 3'd0;
            buf_s    = 32'h0000_0000;
            mem_a_s  = if_addr;
            mem_wr_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        READ: begin
          if (clear) begin
            state_s  = IDLE;
            mem_wr_s = 1'b0;
          end else if (!ready_q_r) begin
            // first cycle after a freeze: address re-driven, capture on the next edge
            mem_a_s = mem_a_r;
          end else begin
            asm_s  = buf_r | (32'(mem_din) << {cnt_r, 3'b000});
            step_s = cnt_r + 3'd1;
            buf_s  = asm_s;
            cnt_s  = step_s;
            if (step_s == len_r) begin
              state_s = DONE;
              if (fetch_r) begin
                if_done_s = 1'b1;
                if_data_s = asm_s;
              end else begin
                lsb_done_s  = 1'b1;
                lsb_rdata_s = asm_s;
              end
            end else begin
              mem_a_s = base_r + 32'(step_s);
            end
          end
        end
        WRITE: begin
          // a byte only counts as written if it was actually driven this cycle
          step_s      = mem_wr_r ? cnt_r + 3'd1 : cnt_r;
          byte_addr_s = base_r + 32'(step_s);
          cnt_s       = step_s;
          if (step_s == len_r) begin
            state_s    = DONE;
            mem_wr_s   = 1'b0;
            lsb_done_s = 1'b1;
          end else begin
            mem_a_s    = byte_addr_s;
            mem_dout_s = 8'(wdata_r >> {step_s, 3'b000});
            mem_wr_s   = !(is_io(byte_addr_s) && io_buffer_full);
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s  = IDLE;
          mem_wr_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      len_r       <= 3'd0;
      base_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      fetch_r     <= 1'b0;
      buf_r       <= 32'h0000_0000;
      ready_q_r   <= 1'b1;
      mem_wr_r    <= 1'b0;
      lsb_done_r  <= 1'b0;
      if_done_r   <= 1'b0;
      lsb_rdata_r <= 32'h0000_0000;
      if_data_r   <= 32'h0000_0000;
      mem_a_r     <= 32'h0000_0000;
      mem_dout_r  <= 8'h00;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      len_r       <= len_s;
      base_r      <= base_s;
      wdata_r     <= wdata_s;
      fetch_r     <= fetch_s;
      buf_r       <= buf_s;
      ready_q_r   <= ready;
      mem_wr_r    <= mem_wr_s;
      lsb_done_r  <= lsb_done_s;
      if_done_r   <= if_done_s;
      lsb_rdata_r <= lsb_rdata_s;
      if_data_r   <= if_data_s;
      mem_a_r     <= mem_a_s;
      mem_dout_r  <= mem_dout_s;
    end
  end

  assign mem_wr    = mem_wr_r & ready;
  assign lsb_done  = lsb_done_r;
  assign if_done   = if_done_r;
  assign lsb_rdata = lsb_rdata_r;
  assign if_data   = if_data_r;
  assign mem_a     = mem_a_r;
  assign mem_dout  = mem_dout_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model answers the bus, expected
// read data is queued at request time and compared on each done pulse.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset, ready, clear;
  logic        lsb_req, lsb_type;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:262143];
  int          io_wr_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lsb_pulses = 0;
  int          if_pulses = 0;
  logic [31:0] lsb_q[$];
  logic [31:0] if_q[$];
  logic [31:0] last_load = 32'h0;

  mem_ctrl #(.IO_SEL_HI(17), .IO_SEL_LO(16)) dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .lsb_req(lsb_req), .lsb_type(lsb_type), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM/IO model: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (reset) begin
      io_wr_cnt      <= 0;
      ram[18'h00100] <= 8'h11; ram[18'h00101] <= 8'h22;
      ram[18'h00102] <= 8'h33; ram[18'h00103] <= 8'h44;
      ram[18'h00200] <= 8'hF0; ram[18'h00201] <= 8'h8A;
      ram[18'h00302] <= 8'h5A;
      ram[18'h00400] <= 8'h93; ram[18'h00401] <= 8'h00;
      ram[18'h00402] <= 8'h10; ram[18'h00403] <= 8'h00;
      ram[18'h00000] <= 8'h13; ram[18'h00001] <= 8'h05;
      ram[18'h00002] <= 8'hA0; ram[18'h00003] <= 8'h02;
      ram[18'h3FFFF] <= 8'h77;
      ram[18'h00600] <= 8'h01; ram[18'h00601] <= 8'h02;
      ram[18'h00602] <= 8'h03; ram[18'h00603] <= 8'h04;
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      if (mem_a == 32'h0003_0000) io_wr_cnt <= io_wr_cnt + 1;
    end
  end

  assign mem_din = ram[mem_a[17:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int n);
    logic [31:0] r = 32'h0;
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      r  = r | (32'(ram[ak[17:0]]) << (8 * k));
    end
    return r;
  endfunction

  // Done-pulse monitor: pops the scoreboard on every completion.
  always @(negedge clk) begin
    if (lsb_done) begin
      lsb_pulses++;
      if (lsb_q.size() == 0) check("lsb_unexpected_done", 32'd1, 32'd0);
      else check("lsb_rdata", lsb_rdata, lsb_q.pop_front());
    end
    if (if_done) begin
      if_pulses++;
      if (if_q.size() == 0) check("if_unexpected_done", 32'd1, 32'd0);
      else check("if_data", if_data, if_q.pop_front());
    end
  end

  // One LSB transaction, started at a negedge; optional clear / freeze windows.
  task automatic lsb_txn(input logic typ, input logic [31:0] a, input logic [1:0] len,
                         input logic [31:0] wd, input int clr_at, input int frz_at,
                         input bit chk_lat);
    int  n = nbytes(len);
    int  i = 0;
    bit  seen = 1'b0;
    if (!typ) last_load = exp_load(a, n);
    lsb_q.push_back(last_load);
    lsb_req = 1'b1; lsb_type = typ; lsb_addr = a; lsb_len = len; lsb_wdata = wd;
    while (!seen && i < 60) begin
      @(negedge clk);
      i++;
      if (lsb_done) seen = 1'b1;
      clear = (i == clr_at) && !seen;
      ready = !(frz_at > 0 && i >= frz_at && i < frz_at + 2 && !seen);
    end
    lsb_req = 1'b0; clear = 1'b0; ready = 1'b1;
    if (!seen) check("lsb_timeout", 32'd0, 32'd1);
    else if (chk_lat) check("lsb_latency", 32'(i), 32'(n + 1));
    @(negedge clk);
  endtask

  initial begin
    int p0, q0, i;
    bit seen;
    reset = 1'b1; ready = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    lsb_req = 1'b0; lsb_type = 1'b0; lsb_addr = 32'h0; lsb_len = 2'b00; lsb_wdata = 32'h0;
    if_req = 1'b0; if_addr = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_lsb_done", 32'(lsb_done), 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);

    // word load, cycle exact, request held through the DONE cycle
    p0 = lsb_pulses;
    last_load = exp_load(32'h100, 4);
    lsb_q.push_back(last_load);
    lsb_req = 1'b1; lsb_type = 1'b0; lsb_addr = 32'h100; lsb_len = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wl_mem_a", mem_a, 32'h100 + 32'(k));
      check("wl_mem_wr", 32'(mem_wr), 32'd0);
    end
    @(negedge clk);
    check("wl_done", 32'(lsb_done), 32'd1);
    @(negedge clk);
    check("wl_done_pulse", 32'(lsb_done), 32'd0);
    lsb_req = 1'b0;
    repeat (3) @(negedge clk);
    check("wl_no_reaccept", mem_a, 32'h103);
    check("wl_pulses", 32'(lsb_pulses - p0), 32'd1);

    // byte, half, len 10 and wrapping loads
    lsb_txn(1'b0, 32'h200, 2'b00, 32'h0, 0, 0, 1'b1);
    lsb_txn(1'b0, 32'h200, 2'b01, 32'h0, 0, 0, 1'b1);
    lsb_txn(1'b0, 32'h600, 2'b10, 32'h0, 0, 0, 1'b1);
    lsb_txn(1'b0, 32'hFFFF_FFFF, 2'b11, 32'h0, 0, 0, 1'b1);

    // half store
    lsb_txn(1'b1, 32'h300, 2'b01, 32'hDEAD_BEEF, 0, 0, 1'b1);
    check("hs_byte0", 32'(ram[18'h00300]), 32'hEF);
    check("hs_byte1", 32'(ram[18'h00301]), 32'hBE);
    check("hs_byte2_kept", 32'(ram[18'h00302]), 32'h5A);

    // collision: LSB first, fetch accepted right after DONE
    p0 = lsb_pulses; q0 = if_pulses;
    last_load = exp_load(32'h100, 4);
    lsb_q.push_back(last_load);
    if_q.push_back(exp_load(32'h400, 4));
    lsb_req = 1'b1; lsb_type = 1'b0; lsb_addr = 32'h100; lsb_len = 2'b11;
    if_req = 1'b1; if_addr = 32'h400;
    i = 0; seen = 1'b0;
    while (!seen && i < 60) begin @(negedge clk); i++; if (lsb_done) seen = 1'b1; end
    lsb_req = 1'b0;
    check("col_lsb_latency", 32'(i), 32'd5);
    check("col_if_not_first", 32'(if_pulses - q0), 32'd0);
    i = 0; seen = 1'b0;
    while (!seen && i < 60) begin @(negedge clk); i++; if (if_done) seen = 1'b1; end
    if_req = 1'b0;
    check("col_if_start", 32'(i), 32'd6);
    repeat (4) @(negedge clk);
    check("col_lsb_pulses", 32'(lsb_pulses - p0), 32'd1);
    check("col_if_pulses", 32'(if_pulses - q0), 32'd1);

    // IO stall on a store
    lsb_q.push_back(last_load);
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_type = 1'b1; lsb_addr = 32'h0003_0000; lsb_len = 2'b00; lsb_wdata = 32'h41;
    repeat (3) begin @(negedge clk); check("io_stall_wr", 32'(mem_wr), 32'd0); end
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_wr", 32'(mem_wr), 32'd1);
    check("io_dout", 32'(mem_dout), 32'h41);
    check("io_addr", mem_a, 32'h0003_0000);
    @(negedge clk);
    check("io_done", 32'(lsb_done), 32'd1);
    lsb_req = 1'b0;
    @(negedge clk);
    check("io_write_count", 32'(io_wr_cnt), 32'd1);

    // fetch cleared after two bytes, then the controller is idle at once
    q0 = if_pulses;
    if_req = 1'b1; if_addr = 32'h0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; if_req = 1'b0;
    check("clr_mem_wr", 32'(mem_wr), 32'd0);
    lsb_txn(1'b0, 32'h200, 2'b00, 32'h0, 0, 0, 1'b1);
    check("clr_no_if_done", 32'(if_pulses - q0), 32'd0);

    // clear during a word store is ignored
    lsb_txn(1'b1, 32'h500, 2'b11, 32'hCAFE_BABE, 2, 0, 1'b1);
    check("cs_word", {ram[18'h00503], ram[18'h00502], ram[18'h00501], ram[18'h00500]}, 32'hCAFE_BABE);

    // ready low for two cycles mid-read
    lsb_txn(1'b0, 32'h100, 2'b11, 32'h0, 0, 2, 1'b0);

    repeat (5) @(negedge clk);
    check("lsb_q_empty", 32'(lsb_q.size()), 32'd0);
    check("if_q_empty", 32'(if_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
